// File: rtl/muldiv_iterative_engine.sv
// Iterative radix-2 multiply / restoring divide engine with MADD/MSUB accumulate.
// Latency: start edge + WIDTH RUN cycles + 1 FIX cycle; result held until ack, restart or clear.
module muldiv_iterative_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             clear,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             dbz
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               div_q, div_d, sub_q, sub_d, sa_q, sa_d, sb_q, sb_d, dbz_q, dbz_d;

  logic               op_ok, op_div, op_sgn, op_acc, op_sub, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;

  always_comb begin
    op_ok  = (funct >= 4'd1) && (funct <= 4'd8);
    op_div = (funct == 4'd3) || (funct == 4'd4);
    op_sgn = (funct == 4'd1) || (funct == 4'd3) || (funct == 4'd5) || (funct == 4'd7);
    op_acc = (funct >= 4'd5) && op_ok;
    op_sub = (funct == 4'd7) || (funct == 4'd8);
    rs_neg = op_sgn & rs[WIDTH-1];
    rt_neg = op_sgn & rt[WIDTH-1];
    rs_mag = rs_neg ? -rs : rs;
    rt_mag = rt_neg ? -rt : rt;
  end

  logic [WIDTH:0]     mul_sum, rem_sh, rem_sub;
  logic               rem_ge, load;
  logic [2*WIDTH-1:0] prod, prod_sgn, mac;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + {1'b0, b_q & {WIDTH{lo_q[0]}}};
    rem_sh   = {hi_q, lo_q[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, b_q};
    rem_sub  = rem_sh - {1'b0, b_q};
    prod     = {hi_q, lo_q};
    prod_sgn = (sa_q ^ sb_q) ? -prod : prod;
    mac      = sub_q ? (acc_q - prod_sgn) : (acc_q + prod_sgn);
    // A zero divisor leaves the magnitude remainder equal to |rs|, so restoring
    // the dividend sign yields rs; only the quotient needs forcing.
    quo      = dbz_q ? '1 : ((sa_q ^ sb_q) ? -lo_q : lo_q);
    rem      = sa_q ? -hi_q : hi_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    acc_d   = acc_q;
    div_d   = div_q;
    sub_d   = sub_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dbz_d   = dbz_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE: load = start && op_ok;
      S_RUN: begin
        if (div_q) begin
          hi_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], rem_ge};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        if (div_q) {hi_d, lo_d} = {rem, quo};
        else       {hi_d, lo_d} = mac;
        state_d = S_DONE;
      end
      default: begin
        if (start && op_ok) load    = 1'b1;
        else if (ack)       state_d = S_IDLE;
      end
    endcase

    if (load) begin
      state_d = S_RUN;
      cnt_d   = CW'(WIDTH - 1);
      hi_d    = '0;
      lo_d    = op_div ? rs_mag : rt_mag;
      b_d     = op_div ? rt_mag : rs_mag;
      acc_d   = op_acc ? {hi_in, lo_in} : '0;
      div_d   = op_div;
      sub_d   = op_sub;
      sa_d    = rs_neg;
      sb_d    = rt_neg;
      dbz_d   = op_div && (rt == '0);
    end

    if (clear) begin
      state_d = S_IDLE;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      div_q   <= 1'b0;
      sub_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      sub_q   <= sub_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy   = (state_q == S_RUN) || (state_q == S_FIX);
  assign valid  = (state_q == S_DONE);
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign dbz    = dbz_q && (state_q == S_DONE);

endmodule
